asic_palette_mixer: RTL and testbench
=====================================

# asic_palette_mixer

Plus-mode (ASIC) palette lookup and final colour stage for the Amstrad video path. Holds the CPU-writable 12-bit palette: 16 pens, border, 15 sprite colours. Converts per-pixel pen indices from the Gate Array/sprite merge into RGB through a fixed 2-cycle pipeline. In CPC mode it delays the legacy RGB by the same latency. Sits between the pixel/sprite merge and the scaler/video output.

## Interface
- NUM_ENTRIES, 32, palette entries; legal 17..32; index width IDX_W = 5
- COLOR_BITS, 4, output bits per channel; legal 4 or 8
- PAL_BASE, 16'h6400, CPU base address of palette in ASIC RAM page
- BORDER_IDX, 16, entry used when pix_border is high
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- plus_mode  in  1  1 = palette lookup, 0 = legacy RGB pass-through
- asic_ram_en  in  1  ASIC register page mapped in
- cpu_addr  in  16  CPU address
- cpu_data  in  8  CPU write data
- cpu_wr  in  1  single-cycle write strobe
- cpu_rd  in  1  single-cycle read strobe
- pal_q  out  8  palette readback byte
- pix_valid  in  1  pixel present this cycle
- pix_index  in  IDX_W  pen/sprite index
- pix_border  in  1  force BORDER_IDX
- pix_blank  in  1  blanking
- r_in, g_in, b_in  in  4 each  legacy CPC RGB
- tp_sel  in  2  test pattern select (only with macro)
- vsync  in  1  frame sync, for test pattern counter
- r_out, g_out, b_out  out  COLOR_BITS each  final colour
- out_valid  out  1  aligned with r/g/b_out
- out_blank  out  1  delayed pix_blank

## Operation
- Palette store: NUM_ENTRIES × 12 bits {R[3:0],G[3:0],B[3:0]}. All entries reset to 12'h000.
- Write decode:
  - A write is accepted when asic_ram_en && cpu_wr && cpu_addr[15:6]==PAL_BASE[15:6] && cpu_addr[5:1] < NUM_ENTRIES.
  - Entry = cpu_addr[5:1].
  - Byte 0 (cpu_addr[0]=0): R ← data[7:4], B ← data[3:0].
  - Byte 1: G ← data[3:0]; data[7:4] is discarded.
  - Out-of-range entries are ignored.
- Readback: on a decoded cpu_rd, pal_q is registered next cycle.
  - Byte 0 returns {R,B}; byte 1 returns {4'h0,G}.
  - Undecoded reads hold pal_q.
- Lookup index:
  - BORDER_IDX if pix_border, else pix_index.
  - An index ≥ NUM_ENTRIES yields 12'h000.
- Stage 1 registers the index or legacy RGB, valid and blank. Stage 2 registers the looked-up or legacy colour.
- Blank: out_blank=1 forces r/g/b_out to 0.
- Expansion:
  - COLOR_BITS=4: the nibble is output unchanged.
  - COLOR_BITS=8: {n,n}, e.g. 4'hA → 8'hAA.
  - Legacy RGB is expanded the same way.
- plus_mode is sampled in stage 1. A mid-line change takes effect on the pixel sampled that cycle; there is no glitch on in-flight pixels.
- pix_valid=0 advances the pipeline with out_valid=0. Outputs hold their last colour.

## Timing
- Pixel latency: 2 clk_sys cycles, pix_valid → out_valid, every cycle (throughput 1/clk).
- Same-entry write and lookup in the same cycle: the lookup sees the old value. A pixel one cycle later sees the new value.
- The palette read occurs in stage 1 → stage 2.
- pal_q latency: 1 cycle after cpu_rd.
- Reset assertion, asynchronous, clears immediately:
  - palette
  - pipeline
  - out_valid, out_blank (both 0)
  - r/g/b_out (all 0)
  - pal_q (8'h00)
  - test counter
- Deassertion is used synchronously by the next clk_sys edge.

## Configuration
- Macro ASIC_PALETTE_TESTPAT_EN.
- Defined: a test-pattern generator substitutes stage-1 colour when plus_mode=1, chosen by tp_sel:
  - tp_sel=0: normal operation.
  - tp_sel=1: palette bars; entry = pixel counter[7:3] mod NUM_ENTRIES.
  - tp_sel=2: 4096-colour sweep {R,G,B} = counter[11:0].
  - tp_sel=3: solid 12'hFFF.
- Pixel counter: 12 bits, increments on each pix_valid, cleared on the vsync falling edge, wraps 4095→0.
- Undefined: tp_sel and vsync are ignored and no counter logic is generated.

## Test plan
- Reset, then pixel idx 3, plus_mode=1 → two cycles later out_valid=1, RGB=0,0,0; pal_q=8'h00.
- Write 0x6406=8'hA5, 0x6407=8'hF3; pixel idx 3 → R=A, G=3, B=5. Readback of 0x6407 → 8'h03.
- With COLOR_BITS=8, write entry 16 = {R=1,G=2,B=3}; pix_border=1 → 8'h11, 8'h22, 8'h33.
- Same-cycle write of entry 5 G=7 and pixel idx 5 → old G. Next pixel → G=7.
- plus_mode=0, r/g/b_in=4'h9 with pix_blank toggling → 9/9/9 after 2 cycles, 0/0/0 on blanked pixels.
- Macro defined, tp_sel=2, 4097 consecutive pixels → colour 12'h000…12'hFFF then 12'h000. vsync fall → counter restarts at 0.

Source files
------------

// File: rtl/asic_palette_mixer_if.sv
// asic_palette_mixer_if: CPU palette-access bus and pixel stream in/out
// for the Plus-mode palette mixer. The master drives CPU accesses and
// pixels; the slave (the mixer) returns the readback byte and final colour.
interface asic_palette_mixer_if #(
  parameter int unsigned IDX_W      = 5,
  parameter int unsigned COLOR_BITS = 4
);
  // CPU access to the ASIC RAM palette page
  logic                  asic_ram_en;
  logic [15:0]           cpu_addr;
  logic [7:0]            cpu_data;
  logic                  cpu_wr;
  logic                  cpu_rd;
  logic [7:0]            pal_q;
  // Pixel stream from the Gate Array / sprite merge
  logic                  pix_valid;
  logic [IDX_W-1:0]      pix_index;
  logic                  pix_border;
  logic                  pix_blank;
  logic [3:0]            r_in;
  logic [3:0]            g_in;
  logic [3:0]            b_in;
  // Final colour towards the scaler / video output
  logic [COLOR_BITS-1:0] r_out;
  logic [COLOR_BITS-1:0] g_out;
  logic [COLOR_BITS-1:0] b_out;
  logic                  out_valid;
  logic                  out_blank;

  modport master (
    output asic_ram_en, cpu_addr, cpu_data, cpu_wr, cpu_rd,
    output pix_valid, pix_index, pix_border, pix_blank, r_in, g_in, b_in,
    input  pal_q, r_out, g_out, b_out, out_valid, out_blank
  );

  modport slave (
    input  asic_ram_en, cpu_addr, cpu_data, cpu_wr, cpu_rd,
    input  pix_valid, pix_index, pix_border, pix_blank, r_in, g_in, b_in,
    output pal_q, r_out, g_out, b_out, out_valid, out_blank
  );
endinterface

// File: rtl/asic_palette_mixer.sv
// asic_palette_mixer: Plus-mode palette store and 2-cycle colour pipeline.
// Optional test-pattern generator enabled by macro ASIC_PALETTE_TESTPAT_EN.
module asic_palette_mixer #(
  parameter int unsigned NUM_ENTRIES = 32,
  parameter int unsigned COLOR_BITS  = 4,
  parameter logic [15:0] PAL_BASE    = 16'h6400,
  parameter int unsigned BORDER_IDX  = 16
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic                 plus_mode,
  input  logic [1:0]           tp_sel,
  input  logic                 vsync,
  asic_palette_mixer_if.slave  bus
);

  localparam int unsigned       IDX_W     = 5;
  localparam logic [IDX_W-1:0]  LP_BORDER = IDX_W'(BORDER_IDX);

  logic [11:0]      r_pal [NUM_ENTRIES];
  logic [7:0]       r_pal_q;
  logic             w_dec;
  logic [IDX_W-1:0] w_cpu_idx;
  logic [11:0]      w_cpu_entry;

  logic             w_s1_usepal;
  logic [IDX_W-1:0] w_s1_idx;
  logic [11:0]      w_s1_rgb;

  logic             r_s1_valid;
  logic             r_s1_blank;
  logic             r_s1_usepal;
  logic [IDX_W-1:0] r_s1_idx;
  logic [11:0]      r_s1_rgb;

  logic [11:0]      w_lookup;
  logic [11:0]      w_s2_col;
  logic [11:0]      r_s2_rgb;
  logic             r_out_valid;
  logic             r_out_blank;

  assign w_cpu_idx   = bus.cpu_addr[5:1];
  assign w_dec       = bus.asic_ram_en &&
                       (bus.cpu_addr[15:6] == PAL_BASE[15:6]) &&
                       (32'(w_cpu_idx) < NUM_ENTRIES);
  assign w_cpu_entry = r_pal[w_cpu_idx];

  // Palette store: byte 0 carries {R,B}, byte 1 carries G in its low nibble
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) r_pal[i] <= '0;
    end else if (w_dec && bus.cpu_wr) begin
      if (!bus.cpu_addr[0]) begin
        r_pal[w_cpu_idx][11:8] <= bus.cpu_data[7:4];
        r_pal[w_cpu_idx][3:0]  <= bus.cpu_data[3:0];
      end else begin
        r_pal[w_cpu_idx][7:4]  <= bus.cpu_data[3:0];
      end
    end
  end

  // Readback register; undecoded reads leave it unchanged
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_pal_q <= '0;
    end else if (w_dec && bus.cpu_rd) begin
      r_pal_q <= bus.cpu_addr[0] ? {4'h0, w_cpu_entry[7:4]}
                                 : {w_cpu_entry[11:8], w_cpu_entry[3:0]};
    end
  end

  assign bus.pal_q = r_pal_q;

`ifdef ASIC_PALETTE_TESTPAT_EN
  logic [11:0]      r_tp_cnt;
  logic             r_vsync_d;
  logic [IDX_W-1:0] w_bar_raw;
  logic [IDX_W-1:0] w_bar_idx;

  assign w_bar_raw = r_tp_cnt[7:3];
  assign w_bar_idx = (32'(w_bar_raw) >= NUM_ENTRIES) ? (w_bar_raw - IDX_W'(NUM_ENTRIES))
                                                     : w_bar_raw;

  // Pixel counter: cleared on vsync falling edge, else counts valid pixels
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_tp_cnt  <= '0;
      r_vsync_d <= 1'b0;
    end else begin
      r_vsync_d <= vsync;
      if (r_vsync_d && !vsync) r_tp_cnt <= '0;
      else if (bus.pix_valid)  r_tp_cnt <= r_tp_cnt + 12'd1;
    end
  end
`else
  logic w_unused_tp;
  assign w_unused_tp = ^{tp_sel, vsync};
`endif

  // Stage-1 source select: palette index, legacy RGB or test pattern
  always_comb begin
    w_s1_usepal = plus_mode;
    w_s1_idx    = bus.pix_border ? LP_BORDER : bus.pix_index;
    w_s1_rgb    = {bus.r_in, bus.g_in, bus.b_in};
`ifdef ASIC_PALETTE_TESTPAT_EN
    if (plus_mode) begin
      case (tp_sel)
        2'd1:    w_s1_idx = w_bar_idx;
        2'd2:    begin w_s1_usepal = 1'b0; w_s1_rgb = r_tp_cnt; end
        2'd3:    begin w_s1_usepal = 1'b0; w_s1_rgb = 12'hFFF; end
        default: ;
      endcase
    end
`endif
  end

  // Stage 1: register index/legacy colour with valid, blank and mode
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_blank  <= 1'b0;
      r_s1_usepal <= 1'b0;
      r_s1_idx    <= '0;
      r_s1_rgb    <= '0;
    end else begin
      r_s1_valid  <= bus.pix_valid;
      r_s1_blank  <= bus.pix_blank;
      r_s1_usepal <= w_s1_usepal;
      r_s1_idx    <= w_s1_idx;
      r_s1_rgb    <= w_s1_rgb;
    end
  end

  // Palette is read here, so a write landing on this edge is not yet seen
  assign w_lookup = (32'(r_s1_idx) < NUM_ENTRIES) ? r_pal[r_s1_idx] : '0;
  assign w_s2_col = r_s1_usepal ? w_lookup : r_s1_rgb;

  // Stage 2: colour updates only on valid pixels, flags every cycle
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_rgb    <= '0;
      r_out_valid <= 1'b0;
      r_out_blank <= 1'b0;
    end else begin
      r_out_valid <= r_s1_valid;
      r_out_blank <= r_s1_blank;
      if (r_s1_valid) r_s2_rgb <= w_s2_col;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_blank = r_out_blank;

  generate
    if (COLOR_BITS == 8) begin : g_exp8
      assign bus.r_out = r_out_blank ? '0 : {r_s2_rgb[11:8], r_s2_rgb[11:8]};
      assign bus.g_out = r_out_blank ? '0 : {r_s2_rgb[7:4],  r_s2_rgb[7:4]};
      assign bus.b_out = r_out_blank ? '0 : {r_s2_rgb[3:0],  r_s2_rgb[3:0]};
    end else begin : g_exp4
      assign bus.r_out = r_out_blank ? '0 : r_s2_rgb[11:8];
      assign bus.g_out = r_out_blank ? '0 : r_s2_rgb[7:4];
      assign bus.b_out = r_out_blank ? '0 : r_s2_rgb[3:0];
    end
  endgenerate

endmodule

// File: tb/tb_asic_palette_mixer.sv
// tb_asic_palette_mixer: directed scoreboard bench for asic_palette_mixer
// (8-bit colour build). Test-pattern steps compile when
// ASIC_PALETTE_TESTPAT_EN is defined.
module tb_asic_palette_mixer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       plus_mode;
  logic [1:0] tp_sel;
  logic       vsync;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] sb[$];
  logic [11:0] m_pal [32];

  asic_palette_mixer_if #(.IDX_W(5), .COLOR_BITS(8)) bus ();

  asic_palette_mixer #(.COLOR_BITS(8)) dut (
    .clk_sys   (clk),
    .reset_n   (reset_n),
    .plus_mode (plus_mode),
    .tp_sel    (tp_sel),
    .vsync     (vsync),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_col(input logic [11:0] c, input logic blank);
    logic [23:0] rgb;
    rgb = blank ? 24'h0 : {c[11:8], c[11:8], c[7:4], c[7:4], c[3:0], c[3:0]};
    return {7'b0, blank, rgb};
  endfunction

  // Output side of the scoreboard
  always @(negedge clk) begin
    if (reset_n && bus.out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out", {31'b0, bus.out_valid}, 32'd0);
      end else begin
        check("pix_out", {7'b0, bus.out_blank, bus.r_out, bus.g_out, bus.b_out}, sb.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input logic upd);
    bus.asic_ram_en = 1'b1;
    bus.cpu_addr    = a;
    bus.cpu_data    = d;
    bus.cpu_wr      = 1'b1;
    step();
    bus.cpu_wr = 1'b0;
    if (upd) begin
      if (!a[0]) begin
        m_pal[a[5:1]][11:8] = d[7:4];
        m_pal[a[5:1]][3:0]  = d[3:0];
      end else begin
        m_pal[a[5:1]][7:4]  = d[3:0];
      end
    end
  endtask

  task automatic cpu_read(input string tag, input logic [15:0] a, input logic [7:0] exp);
    bus.asic_ram_en = 1'b1;
    bus.cpu_addr    = a;
    bus.cpu_rd      = 1'b1;
    step();
    bus.cpu_rd = 1'b0;
    check(tag, {24'b0, bus.pal_q}, {24'b0, exp});
  endtask

  task automatic pix(input logic [4:0] idx, input logic border, input logic blank,
                     input logic [11:0] col);
    bus.pix_valid  = 1'b1;
    bus.pix_index  = idx;
    bus.pix_border = border;
    bus.pix_blank  = blank;
    sb.push_back(exp_col(col, blank));
    step();
    bus.pix_valid  = 1'b0;
    bus.pix_border = 1'b0;
    bus.pix_blank  = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_pal[i] = 12'h000;
    reset_n = 1'b0;
    plus_mode = 1'b0; tp_sel = 2'd0; vsync = 1'b0;
    bus.asic_ram_en = 1'b0; bus.cpu_addr = '0; bus.cpu_data = '0;
    bus.cpu_wr = 1'b0; bus.cpu_rd = 1'b0;
    bus.pix_valid = 1'b0; bus.pix_index = '0; bus.pix_border = 1'b0; bus.pix_blank = 1'b0;
    bus.r_in = '0; bus.g_in = '0; bus.b_in = '0;

    // Reset state
    #12;
    check("rst_valid_blank", {30'b0, bus.out_valid, bus.out_blank}, 32'd0);
    check("rst_rgb", {8'b0, bus.r_out, bus.g_out, bus.b_out}, 32'd0);
    check("rst_pal_q", {24'b0, bus.pal_q}, 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    step();

    // Unwritten entry 3, with exact 2-cycle latency
    plus_mode = 1'b1;
    pix(5'd3, 1'b0, 1'b0, m_pal[3]);
    check("lat_not_yet", {31'b0, bus.out_valid}, 32'd0);
    step();
    check("lat_2cyc", {31'b0, bus.out_valid}, 32'd1);
    cpu_read("rd_reset_entry", 16'h6406, 8'h00);

    // Entry 3 = {A,3,5}; byte 1 upper nibble discarded
    cpu_write(16'h6406, 8'hA5, 1'b1);
    cpu_write(16'h6407, 8'hF3, 1'b1);
    pix(5'd3, 1'b0, 1'b0, 12'hA35);
    cpu_read("rd_g_byte", 16'h6407, 8'h03);
    cpu_read("rd_rb_byte", 16'h6406, 8'hA5);
    cpu_read("rd_undecoded_hold", 16'h6506, 8'hA5);

    // Ignored writes: wrong page, ASIC RAM unmapped
    cpu_write(16'h6606, 8'hFF, 1'b0);
    bus.asic_ram_en = 1'b0;
    bus.cpu_addr = 16'h6406; bus.cpu_data = 8'h00; bus.cpu_wr = 1'b1;
    step();
    bus.cpu_wr = 1'b0;
    cpu_read("rd_after_ignored", 16'h6406, 8'hA5);

    // Border entry 16 = {1,2,3}
    cpu_write(16'h6420, 8'h13, 1'b1);
    cpu_write(16'h6421, 8'hE2, 1'b1);
    pix(5'd3, 1'b1, 1'b0, 12'h123);
    pix(5'd16, 1'b0, 1'b0, 12'h123);

    // Write of entry 5 G lands while the first pixel is being looked up
    cpu_write(16'h640A, 8'h12, 1'b1);
    bus.pix_valid = 1'b1; bus.pix_index = 5'd5;
    sb.push_back(exp_col(12'h102, 1'b0));
    step();
    bus.asic_ram_en = 1'b1; bus.cpu_addr = 16'h640B; bus.cpu_data = 8'h07; bus.cpu_wr = 1'b1;
    sb.push_back(exp_col(12'h172, 1'b0));
    step();
    bus.cpu_wr = 1'b0; bus.pix_valid = 1'b0;
    m_pal[5][7:4] = 4'h7;
    pix(5'd5, 1'b0, 1'b0, 12'h172);

    // Mode switch back-to-back, then legacy RGB with blanking
    bus.r_in = 4'h9; bus.g_in = 4'h9; bus.b_in = 4'h9;
    pix(5'd3, 1'b0, 1'b0, 12'hA35);
    plus_mode = 1'b0;
    for (int i = 0; i < 6; i++) pix(5'd3, 1'b0, i[0], 12'h999);
    pix(5'd3, 1'b0, 1'b0, 12'h999);
    step(); step(); step();
    check("hold_colour", {8'b0, bus.r_out, bus.g_out, bus.b_out}, 32'h00999999);
    check("idle_valid", {31'b0, bus.out_valid}, 32'd0);

`ifdef ASIC_PALETTE_TESTPAT_EN
    // Colour sweep after a vsync falling edge
    plus_mode = 1'b1; tp_sel = 2'd2;
    vsync = 1'b1; step(); vsync = 1'b0; step();
    for (int i = 0; i < 4097; i++) begin
      logic [11:0] c;
      c = 12'(i);
      pix(5'd0, 1'b0, 1'b0, c);
    end
    vsync = 1'b1; step(); vsync = 1'b0; step();
    pix(5'd0, 1'b0, 1'b0, 12'h000);

    // Palette bars then solid white
    cpu_write(16'h6404, 8'h4C, 1'b1);
    cpu_write(16'h6405, 8'h0D, 1'b1);
    tp_sel = 2'd1;
    vsync = 1'b1; step(); vsync = 1'b0; step();
    for (int i = 0; i < 24; i++) pix(5'd9, 1'b0, 1'b0, m_pal[i / 8]);
    tp_sel = 2'd3;
    pix(5'd9, 1'b0, 1'b0, 12'hFFF);
    tp_sel = 2'd0;
`endif

    step(); step(); step();
    check("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
